// File: rtl/traceback_ctrl_if.sv
// Aligned-pair output stream of the traceback controller.
// master: the controller (drives the pair), slave: the downstream consumer.
interface traceback_ctrl_if;
  logic       aln_valid;
  logic       aln_ready;
  logic [2:0] aln_r;
  logic [2:0] aln_q;
  logic       aln_last;

  modport master (
    output aln_valid,
    output aln_r,
    output aln_q,
    output aln_last,
    input  aln_ready
  );

  modport slave (
    input  aln_valid,
    input  aln_r,
    input  aln_q,
    input  aln_last,
    output aln_ready
  );
endinterface

// File: rtl/traceback_ctrl.sv
// traceback_ctrl: sequences one traceback run of the systolic aligner.
// Pairs from the traceback unit arrive bottom-right to top-left. They are
// pushed onto a 2L-deep LIFO and popped back out, so the downstream stream
// runs top-left to bottom-right.
// Optional build macro TB_TIMEOUT_EN: adds a RUN watchdog that aborts the run
// with err after 2L+2 cycles without tb_finish. Without it RUN waits forever.
module traceback_ctrl #(
  parameter int B  = 4,
  parameter int L  = 8,
  parameter int LW = $clog2(2 * L + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    tb_start,
  input  logic                    tb_finish,
  input  logic [2:0]              tb_r,
  input  logic [2:0]              tb_q,
  traceback_ctrl_if.master        aln,
  output logic [LW-1:0]           aln_len,
  output logic                    done,
  output logic                    err
);

  localparam int DEPTH = 2 * L;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // B only sizes the array feeding the traceback unit; reject nonsense here.
  if (B < 1 || L < 1) begin : g_param_check
    $error("traceback_ctrl: B and L must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [LW-1:0]   sp_reg;
  logic [LW-1:0]   len_reg;
  logic            err_reg;
  logic [5:0]      stack_mem [DEPTH];

  logic [LW-1:0]   top_ptr;
  logic [5:0]      top_entry;
  logic            start_acc;
  logic            pair_valid;
  logic            push_req;
  logic            push_ok;
  logic            overflow;
  logic            stack_full;
  logic            stack_empty;
  logic            drain_valid;
  logic            pop;
  logic            timeout;

  // Control decodes shared by the FSM and the datapath registers.
  always_comb begin
    start_acc   = (state_reg == IDLE) && start;
    pair_valid  = ({tb_r, tb_q} != 6'o77);
    stack_full  = (sp_reg == FULL_LVL);
    stack_empty = (sp_reg == '0);
    push_req    = (state_reg == RUN) && pair_valid && !timeout;
    push_ok     = push_req && !stack_full;
    overflow    = push_req && stack_full;
    drain_valid = (state_reg == DRAIN) && !stack_empty;
    pop         = drain_valid && aln.aln_ready;
    top_ptr     = sp_reg - LW'(1);
    top_entry   = stack_mem[top_ptr[AW-1:0]];
  end

`ifdef TB_TIMEOUT_EN
  localparam int CW = $clog2(DEPTH + 3);
  // Last allowed RUN cycle index; the run is 2L+2 cycles long at most.
  localparam logic [CW-1:0] TO_LAST = CW'(DEPTH + 1);

  logic [CW-1:0] cnt_reg;

  // RUN cycle counter, restarted whenever a new run is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (start_acc) begin
      cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign timeout = (state_reg == RUN) && !tb_finish && (cnt_reg == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (tb_finish) begin
          state_next = DRAIN;
        end else if (timeout) begin
          state_next = DONE;
        end
      end
      DRAIN: begin
        // An empty stack (nothing captured, or last pair handed over) ends it.
        if (stack_empty) begin
          state_next = DONE;
        end else if (pop && (sp_reg == LW'(1))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs; the pair outputs park at the invalid code when idle.
  always_comb begin
    busy          = (state_reg != IDLE);
    tb_start      = (state_reg == RUN);
    done          = (state_reg == DONE);
    aln.aln_valid = drain_valid;
    aln.aln_last  = drain_valid && (sp_reg == LW'(1));
    aln.aln_r     = drain_valid ? top_entry[5:3] : 3'd7;
    aln.aln_q     = drain_valid ? top_entry[2:0] : 3'd7;
  end

  assign aln_len = len_reg;
  assign err     = err_reg;

  // Stack pointer: cleared on a new run or an abort, then push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg <= '0;
    end else if (start_acc || timeout) begin
      sp_reg <= '0;
    end else if (push_ok) begin
      sp_reg <= sp_reg + LW'(1);
    end else if (pop) begin
      sp_reg <= sp_reg - LW'(1);
    end
  end

  // Stack storage; entries are never reset, only the pointer matters.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[sp_reg[AW-1:0]] <= {tb_r, tb_q};
    end
  end

  // Sticky error: dropped push or watchdog abort, cleared by the next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (start_acc) begin
      err_reg <= 1'b0;
    end else if (overflow || timeout) begin
      err_reg <= 1'b1;
    end
  end

  // Alignment length, frozen at DRAIN entry including the finish-cycle push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg <= '0;
    end else if ((state_reg == RUN) && tb_finish) begin
      len_reg <= sp_reg + LW'(push_ok);
    end
  end

endmodule

// File: tb/tb_traceback_ctrl.sv
// Scoreboard bench for traceback_ctrl: stimulus tasks queue the expected
// pairs and done/err results, a negedge monitor pops and compares them.
module tb_traceback_ctrl;
  localparam int L     = 8;
  localparam int DEPTH = 2 * L;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       tb_finish = 1'b0;
  logic [2:0] tb_r = 3'd7;
  logic [2:0] tb_q = 3'd7;
  logic       busy;
  logic       tb_start;
  logic       done;
  logic       err;
  logic [4:0] aln_len;

  traceback_ctrl_if aln_if ();

  traceback_ctrl #(.B(4), .L(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .tb_start  (tb_start),
    .tb_finish (tb_finish),
    .tb_r      (tb_r),
    .tb_q      (tb_q),
    .aln       (aln_if),
    .aln_len   (aln_len),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] exp_q[$];       // {r, q, last} in expected delivery order
  logic       exp_err_q[$];   // err expected when done pulses
  int         exp_len = 0;
  logic [5:0] stim[$];        // {r, q} in push order
  bit         ready_manual = 1'b1;
  logic [3:0] ready_pat = 4'b1111;
  int         rdy_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected", name);
  endtask

  // Downstream ready pattern, cycled one entry per clock.
  initial begin
    aln_if.aln_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!ready_manual) begin
        aln_if.aln_ready = ready_pat[rdy_idx];
        rdy_idx = (rdy_idx + 1) % 4;
      end
    end
  end

  // Monitor: compares every handshake and every done pulse with the queues.
  initial begin : monitor
    logic [6:0] held;
    logic [6:0] cur;
    logic [6:0] e;
    bit         held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        cur = {aln_if.aln_r, aln_if.aln_q, aln_if.aln_last};
        if (aln_if.aln_valid) begin
          if (held_v) check("hold_stable", cur, held);
          if (aln_if.aln_ready) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_pair");
            end else begin
              e = exp_q.pop_front();
              check("pair", cur, e);
              check("len_in_drain", aln_len, exp_len);
              $display("pair r=%0d q=%0d last=%0d", cur[6:4], cur[3:1], cur[0]);
            end
            held_v = 1'b0;
          end else begin
            held   = cur;
            held_v = 1'b1;
          end
        end else begin
          held_v = 1'b0;
        end
        if (done) begin
          if (exp_err_q.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            check("err_at_done", err, exp_err_q.pop_front());
            check("pairs_left_at_done", exp_q.size(), 0);
            $display("done err=%0d", err);
          end
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("tb_start_in_run", tb_start, 1);
    check("busy_in_run", busy, 1);
  endtask

  // Drive the stim pairs during RUN; finish either with the last pair or on
  // an extra invalid cycle. auto_exp queues the reversed, depth-limited list.
  task automatic feed(input bit fin_on_last, input bit poke_start, input bit auto_exp);
    int n;
    int kept;
    n    = stim.size();
    kept = (n > DEPTH) ? DEPTH : n;
    if (auto_exp) begin
      exp_len = kept;
      for (int i = kept - 1; i >= 0; i--) exp_q.push_back({stim[i], (i == 0)});
      exp_err_q.push_back(n > DEPTH);
    end
    for (int i = 0; i < n; i++) begin
      tb_r      = stim[i][5:3];
      tb_q      = stim[i][2:0];
      tb_finish = fin_on_last && (i == n - 1);
      start     = poke_start && (i == 2);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!fin_on_last || n == 0) begin
      tb_r = 3'd7; tb_q = 3'd7; tb_finish = 1'b1;
      @(posedge clk);
      #1;
    end
    tb_r = 3'd7; tb_q = 3'd7; tb_finish = 1'b0;
    check("tb_start_drop", tb_start, 0);
    check("busy_in_drain", busy, 1);
    check("len_latch", aln_len, exp_len);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    @(negedge clk);
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_idle_after"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset values while rst is held.
    #2;
    check("rst_busy", busy, 0);
    check("rst_tb_start", tb_start, 0);
    check("rst_valid", aln_if.aln_valid, 0);
    check("rst_last", aln_if.aln_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_r", aln_if.aln_r, 7);
    check("rst_q", aln_if.aln_q, 7);
    check("rst_len", aln_len, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ready_manual = 1'b0;

    // Diagonal of 8 matches, extra finish cycle, start poked mid-run.
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back({3'(i % 4), 3'(i % 4)});
    ready_pat = 4'b1111; rdy_idx = 0;
    do_start();
    feed(1'b0, 1'b1, 1'b1);
    wait_done("diag");

    // Gapped path, finish with the last pair, ready toggling 1,0,0,1.
    stim = '{6'o34, 6'o21, 6'o42, 6'o11};
    exp_q.push_back({3'd1, 3'd1, 1'b0});
    exp_q.push_back({3'd4, 3'd2, 1'b0});
    exp_q.push_back({3'd2, 3'd1, 1'b0});
    exp_q.push_back({3'd3, 3'd4, 1'b1});
    exp_err_q.push_back(1'b0);
    exp_len = 4;
    ready_pat = 4'b1001; rdy_idx = 0;
    do_start();
    feed(1'b1, 1'b0, 1'b0);
    wait_done("gapped");

    // Nothing captured: DRAIN falls straight through to DONE.
    stim.delete();
    ready_pat = 4'b1111;
    do_start();
    feed(1'b0, 1'b0, 1'b1);
    check("empty_valid", aln_if.aln_valid, 0);
    wait_done("empty");

    // 17 valid pushes: the last one is dropped and err is raised.
    stim.delete();
    for (int i = 0; i < 17; i++) stim.push_back({3'(i % 5), 3'((i + 2) % 4)});
    do_start();
    feed(1'b0, 1'b0, 1'b1);
    check("ovf_err", err, 1);
    check("ovf_len", aln_len, 16);
    wait_done("overflow");

`ifdef TB_TIMEOUT_EN
    // No finish ever: watchdog aborts after 18 RUN cycles, nothing delivered.
    begin
      int runs;
      runs = 0;
      exp_len = 0;
      exp_err_q.push_back(1'b1);
      do_start();
      for (int c = 0; c < 100 && !done; c++) begin
        @(negedge clk);
        if (tb_start) runs++;
      end
      check("timeout_run_cycles", runs, 18);
      check("timeout_done", done, 1);
      @(negedge clk);
      check("timeout_idle", busy, 0);
    end
`else
    // No finish for 30 cycles: RUN keeps waiting without error.
    do_start();
    repeat (30) @(posedge clk);
    #1;
    check("wait_busy", busy, 1);
    check("wait_tb_start", tb_start, 1);
    check("wait_err", err, 0);
    check("wait_valid", aln_if.aln_valid, 0);
    stim = '{6'o23};
    feed(1'b1, 1'b0, 1'b1);
    wait_done("wait");
`endif

    // Reset in DRAIN with 3 pairs left, then a fresh alignment.
    ready_manual = 1'b1;
    aln_if.aln_ready = 1'b0;
    stim = '{6'o01, 6'o12, 6'o23, 6'o30, 6'o44};
    do_start();
    feed(1'b0, 1'b0, 1'b1);
    aln_if.aln_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 aln_if.aln_ready = 1'b0;
    check("left_before_rst", exp_q.size(), 3);
    rst = 1'b1;
    exp_q.delete();
    exp_err_q.delete();
    #1;
    check("midrst_valid", aln_if.aln_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_r", aln_if.aln_r, 7);
    check("midrst_len", aln_len, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy, 0);
    ready_manual = 1'b0;
    ready_pat = 4'b1111;
    stim = '{6'o32, 6'o10};
    do_start();
    check("fresh_err", err, 0);
    feed(1'b1, 1'b0, 1'b1);
    wait_done("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
